// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator side of the ALU interface.
// Accepts one request at a time, drives the combinational ALU from registers,
// loops the ALU output back into operand A for multi-bit LSH/RSH, and holds
// the result on a valid/ready response port until the consumer takes it.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds registered RspZero/RspParity.
module alu_sequencer #(
    parameter int unsigned W   = 8,
    parameter int unsigned Ops = 4,
    parameter int unsigned TW  = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           ReqValid,
    output logic           ReqReady,
    input  logic [Ops-1:0] ReqOp,
    input  logic [W-1:0]   ReqA,
    input  logic [W-1:0]   ReqB,
    input  logic [TW-1:0]  ReqTag,
    output logic [W-1:0]   AluA,
    output logic [W-1:0]   AluB,
    output logic [Ops-1:0] AluOp,
    input  logic [W-1:0]   AluOut,
    output logic           RspValid,
    input  logic           RspReady,
    output logic [W-1:0]   RspData,
    output logic [TW-1:0]  RspTag
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic           RspZero,
    output logic           RspParity
`endif
);

    // Shift count field width: one ALU pass shifts by one bit, so at most W-1 passes.
    localparam int unsigned CW = $clog2(W);

    localparam logic [Ops-1:0] OP_ADD = Ops'(0);
    localparam logic [Ops-1:0] OP_LSH = Ops'(1);
    localparam logic [Ops-1:0] OP_RSH = Ops'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [Ops-1:0]  alu_op_q, alu_op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic            rdy_q, vld_q;
    logic            load_c;
    logic            shift_c;
    logic [CW-1:0]   req_cnt_c;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        tag_d     = tag_q;
        load_c    = 1'b0;
        shift_c   = (ReqOp == OP_LSH) || (ReqOp == OP_RSH);
        req_cnt_c = ReqB[CW-1:0];

        case (state_q)
            IDLE: begin
                if (ReqValid && rdy_q) begin
                    alu_a_d  = ReqA;
                    alu_b_d  = ReqB;
                    alu_op_d = ReqOp;
                    tag_d    = ReqTag;
                    if (shift_c && (req_cnt_c == CW'(0))) begin
                        // Zero-bit shift: the operand is already the answer.
                        data_d  = ReqA;
                        load_c  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = shift_c ? req_cnt_c : CW'(1);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == CW'(1)) begin
                    data_d  = AluOut;
                    load_c  = 1'b1;
                    state_d = DONE;
                end else begin
                    // Feed the partial shift back for another single-bit pass.
                    alu_a_d = AluOut;
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (RspReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_ADD;
            cnt_q    <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
        end else begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            rdy_q    <= (state_d == IDLE);
            vld_q    <= (state_d == DONE);
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, par_q;

    // Result flags, loaded only alongside RspData so they stay paired with it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            zero_q <= 1'b0;
            par_q  <= 1'b0;
        end else if (load_c) begin
            zero_q <= (data_d == '0);
            par_q  <= ^data_d;
        end
    end

    assign RspZero   = zero_q;
    assign RspParity = par_q;
`endif

    assign ReqReady = rdy_q;
    assign RspValid = vld_q;
    assign AluA     = alu_a_q;
    assign AluB     = alu_b_q;
    assign AluOp    = alu_op_q;
    assign RspData  = data_q;
    assign RspTag   = tag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed plan steps plus randomized requests,
// checked against a result/latency reference computed from the op rules.
module tb_alu_sequencer;

    localparam int unsigned W   = 8;
    localparam int unsigned OPS = 4;
    localparam int unsigned TW  = 2;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           ReqValid;
    logic           ReqReady;
    logic [OPS-1:0] ReqOp;
    logic [W-1:0]   ReqA;
    logic [W-1:0]   ReqB;
    logic [TW-1:0]  ReqTag;
    logic [W-1:0]   AluA;
    logic [W-1:0]   AluB;
    logic [OPS-1:0] AluOp;
    logic [W-1:0]   AluOut;
    logic           RspValid;
    logic           RspReady;
    logic [W-1:0]   RspData;
    logic [TW-1:0]  RspTag;
`ifdef ALU_SEQ_FLAGS_EN
    logic           RspZero;
    logic           RspParity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_sequencer #(.W(W), .Ops(OPS), .TW(TW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqOp    (ReqOp),
        .ReqA     (ReqA),
        .ReqB     (ReqB),
        .ReqTag   (ReqTag),
        .AluA     (AluA),
        .AluB     (AluB),
        .AluOp    (AluOp),
        .AluOut   (AluOut),
        .RspValid (RspValid),
        .RspReady (RspReady),
        .RspData  (RspData),
        .RspTag   (RspTag)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .RspZero  (RspZero),
        .RspParity(RspParity)
`endif
    );

    always #5 Clk = ~Clk;

    // Combinational ALU: shifts move a single bit per pass.
    always_comb begin
        case (AluOp)
            4'd0:    AluOut = 8'(AluA + AluB);
            4'd1:    AluOut = 8'(AluA << 1);
            4'd2:    AluOut = AluA >> 1;
            4'd3:    AluOut = AluA & AluB;
            4'd4:    AluOut = AluA | AluB;
            4'd5:    AluOut = 8'(8'd0 - AluA);
            4'd6:    AluOut = (AluA >= AluB) ? 8'd1 : 8'd0;
            4'd7:    AluOut = (AluA == AluB) ? 8'd1 : 8'd0;
            4'd8:    AluOut = (AluA != AluB) ? 8'd1 : 8'd0;
            default: AluOut = 8'd0;
        endcase
    end

    // Whole-operation result, shifts done in one step by the full count.
    function automatic logic [7:0] ref_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = int'(b[2:0]);
        case (op)
            4'd0:    return 8'(a + b);
            4'd1:    return 8'(a << n);
            4'd2:    return a >> n;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return 8'(8'd0 - a);
            4'd6:    return (a >= b) ? 8'd1 : 8'd0;
            4'd7:    return (a == b) ? 8'd1 : 8'd0;
            4'd8:    return (a != b) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ReqReady && k < 20) begin
            tick();
            k++;
        end
        chk("req_ready_wait", 32'(ReqReady), 32'd1);
    endtask

    // One full transaction; hold = cycles the consumer stalls after RspValid.
    task automatic do_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] tag, input int hold);
        int k;
        int lat;
        int n;
        logic shift;
        logic [7:0] exp_d;
        logic [7:0] exp_a_done;

        shift      = (op == 4'd1) || (op == 4'd2);
        n          = int'(b[2:0]);
        lat        = !shift ? 2 : ((n == 0) ? 1 : n + 1);
        exp_d      = ref_res(op, a, b);
        exp_a_done = (shift && n > 0) ? ((op == 4'd1) ? 8'(a << (n - 1)) : 8'(a >> (n - 1))) : a;

        RspReady = (hold == 0);
        wait_ready();
        ReqValid = 1'b1;
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        ReqTag   = tag;
        tick();
        ReqValid = 1'b0;
        ReqOp    = 4'($urandom);
        ReqA     = 8'($urandom);
        ReqB     = 8'($urandom);
        ReqTag   = 2'($urandom);

        k = 1;
        while (!RspValid && k < 40) begin
            chk("exec_req_ready", 32'(ReqReady), 32'd0);
            chk("exec_alu_op", 32'(AluOp), 32'(op));
            chk("exec_alu_b", 32'(AluB), 32'(b));
            if (shift)
                chk("exec_alu_a", 32'(AluA), (op == 4'd1) ? 32'(8'(a << (k - 1))) : 32'(8'(a >> (k - 1))));
            else
                chk("exec_alu_a", 32'(AluA), 32'(a));
            tick();
            k++;
        end
        chk("latency", 32'(k), 32'(lat));
        chk("rsp_valid", 32'(RspValid), 32'd1);
        chk("rsp_data", 32'(RspData), 32'(exp_d));
        chk("rsp_tag", 32'(RspTag), 32'(tag));
        chk("done_req_ready", 32'(ReqReady), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero", 32'(RspZero), 32'(exp_d == 8'd0));
        chk("rsp_parity", 32'(RspParity), 32'(^exp_d));
`endif

        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'b1;
            ReqOp    = 4'd0;
            ReqA     = 8'($urandom);
            ReqB     = 8'($urandom);
            ReqTag   = 2'($urandom);
            tick();
            chk("hold_valid", 32'(RspValid), 32'd1);
            chk("hold_data", 32'(RspData), 32'(exp_d));
            chk("hold_tag", 32'(RspTag), 32'(tag));
            chk("hold_req_ready", 32'(ReqReady), 32'd0);
            chk("hold_alu_a", 32'(AluA), 32'(exp_a_done));
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        tick();
        chk("post_rsp_valid", 32'(RspValid), 32'd0);
        chk("post_req_ready", 32'(ReqReady), 32'd1);
        RspReady = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqOp    = '0;
        ReqA     = '0;
        ReqB     = '0;
        ReqTag   = '0;
        RspReady = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_req_ready", 32'(ReqReady), 32'd1);
        chk("rst_rsp_valid", 32'(RspValid), 32'd0);
        chk("rst_alu_a", 32'(AluA), 32'd0);
        chk("rst_alu_b", 32'(AluB), 32'd0);
        chk("rst_alu_op", 32'(AluOp), 32'd0);
        chk("rst_rsp_data", 32'(RspData), 32'd0);
        chk("rst_rsp_tag", 32'(RspTag), 32'd0);

        // Directed plan steps
        do_req(4'd0, 8'h7F, 8'h01, 2'd1, 0);
        do_req(4'd0, 8'hFF, 8'h02, 2'd2, 0);
        do_req(4'd8, 8'h05, 8'h05, 2'd3, 0);
        do_req(4'd1, 8'h03, 8'h03, 2'd0, 0);
        do_req(4'd2, 8'h80, 8'h0B, 2'd1, 0);
        do_req(4'd2, 8'hA5, 8'h00, 2'd2, 0);
        do_req(4'd0, 8'h12, 8'h34, 2'd3, 5);
        do_req(4'd3, 8'hF0, 8'h3C, 2'd1, 0);

        // Reset during the second EXEC cycle of a 5-bit LSH
        wait_ready();
        ReqValid = 1'b1;
        ReqOp    = 4'd1;
        ReqA     = 8'h01;
        ReqB     = 8'h05;
        ReqTag   = 2'd3;
        tick();
        ReqValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_req_ready", 32'(ReqReady), 32'd1);
        chk("abort_rsp_valid", 32'(RspValid), 32'd0);
        chk("abort_alu_a", 32'(AluA), 32'd0);
        chk("abort_alu_op", 32'(AluOp), 32'd0);
        chk("abort_rsp_data", 32'(RspData), 32'd0);
        chk("abort_rsp_tag", 32'(RspTag), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("abort_rsp_zero", 32'(RspZero), 32'd0);
        chk("abort_rsp_parity", 32'(RspParity), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_rsp", 32'(RspValid), 32'd0);
        end

        do_req(4'd7, 8'h3C, 8'h3C, 2'd2, 1);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            do_req(4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom),
                   2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
